// File: rtl/mul_lane_pkg.sv
// Shared types and helpers for the 4-bit multiply execution lane.
// Optional feature macro: MUL_OVF_FLAG_EN (adds an overflow flag to results).
package mul_lane_pkg;

    localparam int unsigned MUL_DATA_W = 4;
    localparam int unsigned MUL_TAG_W  = 5;
    localparam int unsigned MUL_PROD_W = 2 * MUL_DATA_W;

    // Multiply micro-op as delivered by dispatch
    typedef struct packed {
        logic [MUL_DATA_W-1:0] a;
        logic [MUL_DATA_W-1:0] b;
        logic [MUL_TAG_W-1:0]  rd;
    } mul_uop_t;

    // Result payload presented to writeback
    typedef struct packed {
        logic [MUL_DATA_W-1:0] data;
        logic [MUL_TAG_W-1:0]  rd;
`ifdef MUL_OVF_FLAG_EN
        logic                  ovf;
`endif
    } mul_res_t;

    // Unsigned multiply, truncated to DATA_W; an x0 destination yields a zero result
    function automatic mul_res_t mul_exec(input mul_uop_t uop);
        mul_res_t res;
`ifdef MUL_OVF_FLAG_EN
        logic [MUL_PROD_W-1:0] prod;
        prod = MUL_PROD_W'(uop.a) * MUL_PROD_W'(uop.b);
`else
        logic [MUL_DATA_W-1:0] prod;
        prod = uop.a * uop.b;
`endif
        res    = '0;
        res.rd = uop.rd;
        if (uop.rd != '0) begin
            res.data = prod[MUL_DATA_W-1:0];
`ifdef MUL_OVF_FLAG_EN
            res.ovf  = |prod[MUL_PROD_W-1:MUL_DATA_W];
`endif
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_uop_fifo.sv
// Circular queue of multiply micro-ops with synchronous flush.
module mul_uop_fifo
    import mul_lane_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             push,
    input  mul_uop_t                         push_data,
    input  logic                             pop,
    output mul_uop_t                         head,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mul_uop_t           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    // Pointer and occupancy update; flush empties the queue and rewinds pointers
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents are meaningless while the count says empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mul_issue_buffer.sv
// Issue buffer for the multiply lane: micro-op queue, multiplier and result register.
// Optional feature macro: MUL_OVF_FLAG_EN (adds wb_ovf output).
module mul_issue_buffer
    import mul_lane_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MUL_DATA_W-1:0]  in_a,
    input  logic [MUL_DATA_W-1:0]  in_b,
    input  logic [MUL_TAG_W-1:0]   in_rd,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [MUL_DATA_W-1:0]  wb_data,
    output logic [MUL_TAG_W-1:0]   wb_rd,
    output logic                   busy
`ifdef MUL_OVF_FLAG_EN
    ,
    output logic                   wb_ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    mul_uop_t          w_in_uop;
    mul_uop_t          w_head;
    mul_res_t          w_res;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    mul_res_t          r_res;
    logic              r_wb_valid;

    assign w_in_uop = {in_a, in_b, in_rd};
    // Ready ignores a same-cycle pop so it never depends on wb_ready
    assign in_ready = !w_full && !flush;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && (!r_wb_valid || wb_ready) && !flush;
    assign w_res    = mul_exec(w_head);

    mul_uop_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (w_push),
        .push_data (w_in_uop),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Result register: load on issue, clear on retire or flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_res      <= '0;
        end else if (flush) begin
            r_wb_valid <= 1'b0;
            r_res      <= '0;
        end else if (w_pop) begin
            r_wb_valid <= 1'b1;
            r_res      <= w_res;
        end else if (wb_ready) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_data  = r_res.data;
    assign wb_rd    = r_res.rd;
    assign busy     = (w_count != '0) || r_wb_valid;
`ifdef MUL_OVF_FLAG_EN
    assign wb_ovf   = r_res.ovf;
`endif

endmodule

// File: tb/tb_mul_issue_buffer.sv
// Directed self-checking bench for mul_issue_buffer.
// Optional feature macro: MUL_OVF_FLAG_EN (also checks wb_ovf).
module tb_mul_issue_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [4:0]  in_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_data;
    logic [4:0]  wb_rd;
    logic        busy;
`ifdef MUL_OVF_FLAG_EN
    logic        wb_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_res;
    int exp_idx;

    always #5 clk = ~clk;

    mul_issue_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_rd    (in_rd),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .busy     (busy)
`ifdef MUL_OVF_FLAG_EN
        ,
        .wb_ovf   (wb_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [4:0] rd);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
    endtask

    // Leaves 2 ops queued and result 2*3=6 (rd 1) stalled in writeback
    task automatic fill_stalled();
        wb_ready = 1'b0;
        drive(1'b1, 4'h2, 4'h3, 5'd1);
        tick();
        drive(1'b1, 4'h4, 4'h4, 5'd2);
        tick();
        drive(1'b1, 4'h5, 4'h3, 5'd3);
        tick();
        drive(1'b0, 4'h0, 4'h0, 5'd0);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b0;
        drive(1'b1, 4'h1, 4'h1, 5'd1);

        // Reset held with in_valid asserted
        repeat (3) tick();
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 5'd0);
        tick();
        chk("rst_no_push_busy", 32'(busy), 0);
        chk("rst_no_push_valid", 32'(wb_valid), 0);

        // Single op 3*5 -> F, one cycle of latency after the push edge
        wb_ready = 1'b1;
        drive(1'b1, 4'h3, 4'h5, 5'd7);
        tick();
        drive(1'b0, 4'h0, 4'h0, 5'd0);
        chk("single_not_yet", 32'(wb_valid), 0);
        chk("single_busy", 32'(busy), 1);
        tick();
        chk("single_valid", 32'(wb_valid), 1);
        chk("single_data", 32'(wb_data), 'hF);
        chk("single_rd", 32'(wb_rd), 7);
        tick();
        chk("single_retire", 32'(wb_valid), 0);
        chk("single_idle", 32'(busy), 0);

        // Truncation F*3 = 2D -> D
        drive(1'b1, 4'hF, 4'h3, 5'd9);
        tick();
        drive(1'b0, 4'h0, 4'h0, 5'd0);
        tick();
        chk("trunc_data", 32'(wb_data), 'hD);
        chk("trunc_rd", 32'(wb_rd), 9);
`ifdef MUL_OVF_FLAG_EN
        chk("trunc_ovf", 32'(wb_ovf), 1);
`endif
        tick();

        // Back-pressure: hold first result, stall dispatch, then drain in order
        fill_stalled();
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_data0", 32'(wb_data), 6);
        chk("bp_rd0", 32'(wb_rd), 1);
        tick();
        chk("bp_hold_data", 32'(wb_data), 6);
        chk("bp_hold_rd", 32'(wb_rd), 1);
        chk("bp_hold_valid", 32'(wb_valid), 1);
        wb_ready = 1'b1;
        tick();
        chk("bp_data1", 32'(wb_data), 0);
        chk("bp_rd1", 32'(wb_rd), 2);
`ifdef MUL_OVF_FLAG_EN
        chk("bp_ovf1", 32'(wb_ovf), 1);
`endif
        tick();
        chk("bp_data2", 32'(wb_data), 'hF);
        chk("bp_rd2", 32'(wb_rd), 3);
        chk("bp_valid2", 32'(wb_valid), 1);
        tick();
        chk("bp_drained", 32'(wb_valid), 0);

        // Flush with full queue, pending result and an incoming op
        fill_stalled();
        wb_ready = 1'b1;
        flush    = 1'b1;
        drive(1'b1, 4'h7, 4'h7, 5'd4);
        #1;
        chk("flush_ready_low", 32'(in_ready), 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 5'd0);
        #1;
        chk("flush_wb_valid", 32'(wb_valid), 0);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        n_res = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_valid) n_res++;
        end
        chk("flush_dropped", n_res, 0);

        // x0 destination stream, back-to-back across pointer wrap
        n_res = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'h2, 4'h2, 5'd0);
            tick();
            if (wb_valid) begin
                chk("x0_data", 32'(wb_data), 0);
                n_res++;
            end
        end
        drive(1'b0, 4'h0, 4'h0, 5'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wb_valid) begin
                chk("x0_data", 32'(wb_data), 0);
                n_res++;
            end
        end
        chk("x0_count", n_res, 6);

        // Ordered stream with distinct tags: op i is i*1 to rd i
        exp_idx = 1;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 4'(i), 4'h1, 5'(i));
            tick();
            if (wb_valid) begin
                chk("order_data", 32'(wb_data), 32'(exp_idx));
                chk("order_rd", 32'(wb_rd), 32'(exp_idx));
                exp_idx++;
            end
        end
        drive(1'b0, 4'h0, 4'h0, 5'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wb_valid) begin
                chk("order_data", 32'(wb_data), 32'(exp_idx));
                chk("order_rd", 32'(wb_rd), 32'(exp_idx));
                exp_idx++;
            end
        end
        chk("order_count", exp_idx, 7);
        chk("final_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
